// File: rtl/microcode_sequencer_if.sv
// Microword/sequencer bus between the condition tester, decoder and the micro-PC sequencer.
// The master drives the microword fields. The slave is the sequencer and drives the address and status.
interface microcode_sequencer_if #(
  parameter int unsigned UPC_WIDTH   = 9,
  parameter int unsigned STACK_DEPTH = 4
);
  localparam int unsigned LVL_W = $clog2(STACK_DEPTH + 1);

  logic                 stall;
  logic                 condition;
  logic [2:0]           branch_op;
  logic [UPC_WIDTH-1:0] branch_target;
  logic [UPC_WIDTH-1:0] decode_addr;
  logic                 decode_valid;
  logic                 exception;
  logic [UPC_WIDTH-1:0] exception_addr;
  logic [UPC_WIDTH-1:0] next_upc;
  logic [UPC_WIDTH-1:0] micro_pc;
  logic [LVL_W-1:0]     stack_level;
  logic                 halted;
  logic                 stack_overflow;
  logic                 stack_underflow;

  modport master (
    output stall, condition, branch_op, branch_target, decode_addr, decode_valid,
           exception, exception_addr,
    input  next_upc, micro_pc, stack_level, halted, stack_overflow, stack_underflow
  );

  modport slave (
    input  stall, condition, branch_op, branch_target, decode_addr, decode_valid,
           exception, exception_addr,
    output next_upc, micro_pc, stack_level, halted, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/microcode_sequencer.sv
// MC68000 microprogram sequencer: micro-PC register, return stack, dispatch and exception entry.
// next_upc is combinational so it can address a synchronous microcode ROM directly.
module microcode_sequencer #(
  parameter int unsigned UPC_WIDTH   = 9,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  microcode_sequencer_if.slave  bus
);
  localparam int unsigned LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_NEXT     = 3'b000;
  localparam logic [2:0] OP_JUMP     = 3'b001;
  localparam logic [2:0] OP_BR_TRUE  = 3'b010;
  localparam logic [2:0] OP_BR_FALSE = 3'b011;
  localparam logic [2:0] OP_CALL     = 3'b100;
  localparam logic [2:0] OP_RETURN   = 3'b101;
  localparam logic [2:0] OP_DISPATCH = 3'b110;
  localparam logic [2:0] OP_HALT     = 3'b111;

  logic [UPC_WIDTH-1:0] upc_q, upc_d, upc_inc;
  logic [LVL_W-1:0]     level_q;
  logic                 halted_q, ovf_q, unf_q;
  logic [UPC_WIDTH-1:0] stack_mem [STACK_DEPTH];

  logic             push, pop, halt_set, ovf_set, unf_set;
  logic             stack_full, stack_empty;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign upc_inc     = upc_q + UPC_WIDTH'(1);
  assign stack_full  = (level_q == LVL_W'(STACK_DEPTH));
  assign stack_empty = (level_q == '0);
  assign wr_idx      = IDX_W'(level_q);
  assign rd_idx      = IDX_W'(level_q - LVL_W'(1));

  // Exception outranks halt and stall; halt and stall both simply hold the micro-PC.
  always_comb begin
    upc_d    = upc_q;
    push     = 1'b0;
    pop      = 1'b0;
    halt_set = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    if (bus.exception) begin
      upc_d = bus.exception_addr;
    end else if (!halted_q && !bus.stall) begin
      case (bus.branch_op)
        OP_NEXT:     upc_d = upc_inc;
        OP_JUMP:     upc_d = bus.branch_target;
        OP_BR_TRUE:  upc_d = bus.condition ? bus.branch_target : upc_inc;
        OP_BR_FALSE: upc_d = bus.condition ? upc_inc : bus.branch_target;
        OP_CALL: begin
          upc_d   = bus.branch_target;
          push    = !stack_full;
          ovf_set = stack_full;
        end
        OP_RETURN: begin
          upc_d   = stack_empty ? '0 : stack_mem[rd_idx];
          pop     = !stack_empty;
          unf_set = stack_empty;
        end
        OP_DISPATCH: upc_d = bus.decode_valid ? bus.decode_addr : upc_q;
        OP_HALT: begin
          upc_d    = upc_q;
          halt_set = 1'b1;
        end
        default:     upc_d = upc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc_q    <= '0;
      level_q  <= '0;
      halted_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      upc_q <= upc_d;
      if (bus.exception) begin
        level_q  <= '0;
        halted_q <= 1'b0;
      end else begin
        if (push) level_q <= level_q + LVL_W'(1);
        if (pop)  level_q <= level_q - LVL_W'(1);
        if (halt_set) halted_q <= 1'b1;
        if (ovf_set)  ovf_q    <= 1'b1;
        if (unf_set)  unf_q    <= 1'b1;
      end
    end
  end

  // Stack contents are don't-care after reset; only the level pointer is cleared.
  always_ff @(posedge clk) begin
    if (push) stack_mem[wr_idx] <= upc_inc;
  end

  assign bus.next_upc        = upc_d;
  assign bus.micro_pc        = upc_q;
  assign bus.stack_level     = level_q;
  assign bus.halted          = halted_q;
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;
endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed scenarios plus random microword streams,
// checked against a queue-based model of the sequencing rules.
module tb_microcode_sequencer;
  localparam int unsigned W = 9;
  localparam int unsigned D = 4;
  typedef logic [W-1:0] addr_t;

  localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, BRT = 3'd2, BRF = 3'd3,
                         CALL = 3'd4, RET = 3'd5, DISP = 3'd6, HALT = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  microcode_sequencer_if #(.UPC_WIDTH(W), .STACK_DEPTH(D)) bus ();
  microcode_sequencer #(.UPC_WIDTH(W), .STACK_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  addr_t m_pc;
  addr_t m_stk[$];
  bit    m_halt, m_ovf, m_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pc"},    32'(bus.micro_pc), 32'(m_pc));
    check({tag, ".level"}, 32'(bus.stack_level), 32'(m_stk.size()));
    check({tag, ".halt"},  32'(bus.halted), 32'(m_halt));
    check({tag, ".ovf"},   32'(bus.stack_overflow), 32'(m_ovf));
    check({tag, ".unf"},   32'(bus.stack_underflow), 32'(m_unf));
  endtask

  task automatic model_reset();
    m_pc = '0;
    m_stk.delete();
    m_halt = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic drive(input logic [2:0] op, input addr_t tgt, input logic cond, input logic stl,
                       input logic dv, input addr_t da, input logic ex, input addr_t ea);
    bus.branch_op      = op;
    bus.branch_target  = tgt;
    bus.condition      = cond;
    bus.stall          = stl;
    bus.decode_valid   = dv;
    bus.decode_addr    = da;
    bus.exception      = ex;
    bus.exception_addr = ea;
  endtask

  // Called just after a rising edge; drives one microword and checks next_upc and the new state.
  task automatic cyc(input string tag, input logic [2:0] op, input addr_t tgt = '0,
                     input logic cond = 1'b0, input logic stl = 1'b0, input logic dv = 1'b0,
                     input addr_t da = '0, input logic ex = 1'b0, input addr_t ea = '0);
    addr_t exp_next;
    addr_t inc;
    addr_t n_stk[$];
    bit n_halt, n_ovf, n_unf;
    inc = addr_t'(m_pc + 1);
    n_stk = m_stk;
    n_halt = m_halt;
    n_ovf = m_ovf;
    n_unf = m_unf;
    drive(op, tgt, cond, stl, dv, da, ex, ea);
    #2;
    if (ex) begin
      exp_next = ea;
      n_stk.delete();
      n_halt = 0;
    end else if (m_halt || stl) begin
      exp_next = m_pc;
    end else begin
      case (op)
        NEXT: exp_next = inc;
        JUMP: exp_next = tgt;
        BRT:  exp_next = cond ? tgt : inc;
        BRF:  exp_next = cond ? inc : tgt;
        CALL: begin
          exp_next = tgt;
          if (n_stk.size() < D) n_stk.push_back(inc);
          else n_ovf = 1;
        end
        RET: begin
          if (n_stk.size() == 0) begin
            exp_next = '0;
            n_unf = 1;
          end else exp_next = n_stk.pop_back();
        end
        DISP: exp_next = dv ? da : m_pc;
        default: begin
          exp_next = m_pc;
          n_halt = 1;
        end
      endcase
    end
    check({tag, ".next"}, 32'(bus.next_upc), 32'(exp_next));
    @(posedge clk);
    #1;
    m_pc = exp_next;
    m_stk = n_stk;
    m_halt = n_halt;
    m_ovf = n_ovf;
    m_unf = n_unf;
    check_state(tag);
  endtask

  // Entered just after a rising edge; leaves just after the next one with reset released.
  task automatic do_reset(input string tag);
    drive(NEXT, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] op;
    model_reset();
    drive(NEXT, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    #1;
    check_state("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) cyc("next", NEXT);
    check("next3", 32'(bus.micro_pc), 32'h3);
    cyc("jmp1ff", JUMP, 9'h1FF);
    cyc("wrap", NEXT);
    check("wrap0", 32'(bus.micro_pc), 32'h0);

    cyc("j010", JUMP, 9'h010);
    cyc("brt", BRT, 9'h080, 1'b1);
    check("brt080", 32'(bus.micro_pc), 32'h080);
    cyc("brf", BRF, 9'h0C0, 1'b1);
    check("brf081", 32'(bus.micro_pc), 32'h081);
    cyc("brt0", BRT, 9'h1AA, 1'b0);
    cyc("brf0", BRF, 9'h0C0, 1'b0);

    cyc("j020", JUMP, 9'h020);
    cyc("call1", CALL, 9'h100);
    cyc("call2", CALL, 9'h140);
    check("lvl2", 32'(bus.stack_level), 32'd2);
    cyc("ret1", RET);
    check("ret101", 32'(bus.micro_pc), 32'h101);
    cyc("ret2", RET);
    check("ret021", 32'(bus.micro_pc), 32'h021);

    for (int i = 0; i < 5; i++) cyc("ncall", CALL, addr_t'(9'h180 + 9'(i * 8)));
    check("ovf_lvl", 32'(bus.stack_level), 32'd4);
    check("ovf_flag", 32'(bus.stack_overflow), 32'd1);
    for (int i = 0; i < 5; i++) cyc("nret", RET);
    check("unf_pc", 32'(bus.micro_pc), 32'h0);
    check("unf_flag", 32'(bus.stack_underflow), 32'd1);
    for (int i = 0; i < 3; i++) cyc("sticky", NEXT);
    do_reset("rst_sticky");

    for (int i = 0; i < 3; i++) cyc("disp_wait", DISP, '0, 1'b0, 1'b0, 1'b0, 9'h0A5);
    cyc("disp", DISP, '0, 1'b0, 1'b0, 1'b1, 9'h0A5);
    check("disp0a5", 32'(bus.micro_pc), 32'h0A5);
    for (int i = 0; i < 3; i++) cyc("stall", JUMP, 9'h033, 1'b0, 1'b1);
    cyc("unstall", JUMP, 9'h033);
    check("jmp033", 32'(bus.micro_pc), 32'h033);

    cyc("hcall1", CALL, 9'h050);
    cyc("hcall2", CALL, 9'h060);
    cyc("halt", HALT);
    cyc("halted", NEXT);
    cyc("halted", CALL, 9'h111);
    check("halt1", 32'(bus.halted), 32'd1);
    cyc("exc", NEXT, '0, 1'b0, 1'b1, 1'b0, '0, 1'b1, 9'h004);
    check("exc004", 32'(bus.micro_pc), 32'h004);
    check("exc_lvl", 32'(bus.stack_level), 32'd0);
    cyc("exc_stall", JUMP, 9'h077, 1'b0, 1'b1, 1'b0, '0, 1'b1, 9'h008);

    cyc("mcall1", CALL, 9'h0F0);
    drive(CALL, 9'h0F8, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_pc", 32'(bus.micro_pc), 32'h0);
    check("midrst_lvl", 32'(bus.stack_level), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int n = 0; n < 800; n++) begin
      op = 3'($urandom_range(0, 7));
      if (op == HALT && $urandom_range(0, 3) != 0) op = NEXT;
      if (n == 400) do_reset("rnd_rst");
      cyc("rnd", op, addr_t'($urandom_range(0, 511)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), addr_t'($urandom_range(0, 511)),
          ($urandom_range(0, 24) == 0), addr_t'($urandom_range(0, 511)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
